// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter and next-PC selection with sticky fault trap
module fetch_pc_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_3000,
    parameter int          ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        npc_sel,
    input  logic              br_taken,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [31:0]       ra,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic [ADDR_W-1:0] im_addr,
    output logic              fault,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam logic [32:0] LOW_BOUND  = {1'b0, PC_INIT};
    localparam logic [32:0] HIGH_BOUND = LOW_BOUND + (33'd4 << ADDR_W);

    state_t      state;
    logic [31:0] tgt;
    logic [31:0] brOffset;
    logic        tgtLegal;

    assign pc_plus4 = pc + 32'd4;
    assign brOffset = {{14{imm16[15]}}, imm16, 2'b00};

    // PC_INIT is word aligned, so the low two bits never borrow into the word index
    assign im_addr = pc[ADDR_W+1:2] - PC_INIT[ADDR_W+1:2];

    always_comb begin
        tgt = pc_plus4;
        unique case (npc_sel)
            2'b00: tgt = pc_plus4;
            2'b01: tgt = br_taken ? (pc_plus4 + brOffset) : pc_plus4;
            2'b10: tgt = {pc_plus4[31:28], imm26, 2'b00};
            2'b11: tgt = ra;
        endcase
    end

    assign tgtLegal = (tgt[1:0] == 2'b00)
                   && ({1'b0, tgt} >= LOW_BOUND)
                   && ({1'b0, tgt} <  HIGH_BOUND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            pc        <= PC_INIT;
            fault     <= 1'b0;
            fetch_cnt <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (!stall) begin
                        if (tgtLegal) begin
                            pc <= tgt;
                            if (fetch_cnt != 32'hFFFF_FFFF)
                                fetch_cnt <= fetch_cnt + 32'd1;
                        end else begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end
                    end
                end
                FAULT: begin
                    // frozen until reset
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit against an arithmetic reference model
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npcSel;
    logic        brTaken;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] ra;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [9:0]  imAddr;
    logic        fault;
    logic [31:0] fetchCnt;

    fetch_pc_unit #(.PC_INIT(32'h0000_3000), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .stall(stall), .npc_sel(npcSel),
        .br_taken(brTaken), .imm16(imm16), .imm26(imm26), .ra(ra),
        .pc(pc), .pc_plus4(pcPlus4), .im_addr(imAddr), .fault(fault),
        .fetch_cnt(fetchCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint pcE;
        longint pcPlus4E;
        longint imAddrE;
        longint faultE;
        longint cntE;
    } expect_t;

    expect_t expQ[$];
    int total = 0;
    int bad = 0;

    // reference model state
    longint mPc;
    longint mCnt;
    bit     mFault;

    localparam longint MASK32 = 64'hFFFF_FFFF;
    localparam longint BASE   = 64'h3000;
    localparam longint SPAN   = 4 * 1024;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic expect_t modelView();
        expect_t e;
        e.pcE      = mPc;
        e.pcPlus4E = (mPc + 4) & MASK32;
        e.imAddrE  = ((mPc - BASE) / 4) % 1024;
        e.faultE   = mFault ? 1 : 0;
        e.cntE     = mCnt;
        return e;
    endfunction

    task automatic checkNow(input string tag);
        expect_t e;
        e = modelView();
        chk({tag, ".pc"}, longint'(pc), e.pcE);
        chk({tag, ".pc_plus4"}, longint'(pcPlus4), e.pcPlus4E);
        chk({tag, ".im_addr"}, longint'(imAddr), e.imAddrE);
        chk({tag, ".fault"}, longint'(fault), e.faultE);
        chk({tag, ".fetch_cnt"}, longint'(fetchCnt), e.cntE);
    endtask

    function automatic void modelStep(bit st, int sel, bit bt, logic [15:0] i16,
                                      logic [25:0] i26, logic [31:0] r);
        longint p4;
        longint t;
        if (mFault || st) return;
        p4 = (mPc + 4) & MASK32;
        case (sel)
            0:       t = p4;
            1:       t = bt ? ((p4 + longint'($signed(i16)) * 4) & MASK32) : p4;
            2:       t = (p4 / (64'd1 << 28)) * (64'd1 << 28) + longint'(i26) * 4;
            default: t = longint'(r);
        endcase
        if ((t % 4 == 0) && t >= BASE && t < BASE + SPAN) begin
            mPc  = t;
            mCnt = (mCnt == MASK32) ? MASK32 : mCnt + 1;
        end else begin
            mFault = 1'b1;
        end
    endfunction

    // entered and left just after a falling edge
    task automatic step(input bit st, input int sel, input bit bt, input logic [15:0] i16,
                        input logic [25:0] i26, input logic [31:0] r);
        stall   = st;
        npcSel  = 2'(sel);
        brTaken = bt;
        imm16   = i16;
        imm26   = i26;
        ra      = r;
        modelStep(st, sel, bt, i16, i26, r);
        expQ.push_back(modelView());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic seqStep();
        step(0, 0, 0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic jr(input logic [31:0] r);
        step(0, 3, 0, 16'h0, 26'h0, r);
    endtask

    // asynchronous reset between edges, checked before any edge arrives
    task automatic midReset(input string tag);
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        mPc = BASE; mCnt = 0; mFault = 1'b0;
        checkNow(tag);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        expect_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("mon.pc", longint'(pc), e.pcE);
            chk("mon.pc_plus4", longint'(pcPlus4), e.pcPlus4E);
            chk("mon.im_addr", longint'(imAddr), e.imAddrE);
            chk("mon.fault", longint'(fault), e.faultE);
            chk("mon.fetch_cnt", longint'(fetchCnt), e.cntE);
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b1; npcSel = 2'b00; brTaken = 1'b0;
        imm16 = 16'h0; imm26 = 26'h0; ra = 32'h0;
        mPc = BASE; mCnt = 0; mFault = 1'b0;
        #3;
        checkNow("reset");
        #4 reset = 1'b0;
        @(negedge clk);

        repeat (4) seqStep();
        chk("seq4.pc", longint'(pc), 64'h3010);
        chk("seq4.im_addr", longint'(imAddr), 4);

        jr(32'h3008);
        step(0, 1, 1, 16'hFFFE, 26'h0, 32'h0);
        chk("br_taken.pc", longint'(pc), 64'h3004);
        jr(32'h3008);
        step(0, 1, 0, 16'hFFFE, 26'h0, 32'h0);
        chk("br_not_taken.pc", longint'(pc), 64'h300C);
        step(0, 1, 1, 16'hFFFF, 26'h0, 32'h0);
        chk("self_loop.pc", longint'(pc), 64'h300C);
        step(0, 2, 1, 16'h0, 26'h3FF_FFFF, 32'h0);

        mFault = 1'b0;
        midReset("reset2");
        step(0, 2, 0, 16'h0, 26'h0000C05, 32'h0);
        chk("jump.pc", longint'(pc), 64'h3014);
        jr(32'h3000);
        jr(32'h3FFC);
        chk("jr.im_addr", longint'(imAddr), 1023);

        repeat (3) step(1, 3, 1, 16'h0, 26'h0, 32'h3100);
        jr(32'h3100);
        chk("stall_release.pc", longint'(pc), 64'h3100);

        force dut.fetch_cnt = 32'hFFFF_FFFF;
        mCnt = MASK32;
        seqStep();
        release dut.fetch_cnt;
        #1;
        chk("sat.hold", longint'(fetchCnt), MASK32);
        seqStep();

        jr(32'h3FFC);
        seqStep();
        chk("fault.seq_end", longint'(fault), 1);
        jr(32'h3000);
        seqStep();
        midReset("reset_in_fault");
        seqStep();
        chk("after_reset.pc", longint'(pc), 64'h3004);
        jr(32'h3002);
        midReset("reset_misaligned");
        jr(32'h2FFC);
        midReset("reset_below");

        for (int i = 0; i < 1500; i++) begin
            bit st;
            int sel;
            logic [15:0] i16;
            logic [31:0] r;
            st  = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 3);
            i16 = 16'($signed($urandom_range(0, 80)) - 40);
            r   = 32'h2FF0 + 32'($urandom_range(0, 4127));
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            step(st, sel, 1'($urandom_range(0, 1)), i16,
                 26'h0000C00 + 26'($urandom_range(0, 1030)), r);
            if (mFault && $urandom_range(0, 3) == 0) midReset("rand_reset");
        end

        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
        chk("queue_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
